// File: rtl/hs_buf_pkg.sv
// Shared state type, output-mode constants and sizing helpers for the
// handshake elastic buffer.
package hs_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_buf_ram.sv
// DEPTH x DATA_WD register array: one synchronous write port and an
// asynchronous read port, so the head entry is visible without a read cycle.
module hs_buf_ram #(
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 4,
    parameter int AW      = 2
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DATA_WD-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [DATA_WD-1:0] rd_data
);

    logic [DATA_WD-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/hs_elastic_buf.sv
// Parametrised valid/ready elastic buffer: circular storage, occupancy
// count, almost-full flag, synchronous flush and optional fall-through.
module hs_elastic_buf
    import hs_buf_pkg::*;
#(
    parameter int DATA_WD  = 32,
    parameter int DEPTH    = 4,
    parameter int MODE     = MODE_REG,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       valid_in,
    input  logic [DATA_WD-1:0]         data_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [DATA_WD-1:0]         data_out,
    input  logic                       ready_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       afull
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hs_elastic_buf: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
        $error("hs_elastic_buf: AFULL_TH must lie in 1..DEPTH");
    end
    if ((MODE != MODE_REG) && (MODE != MODE_FWFT)) begin : g_bad_mode
        $error("hs_elastic_buf: MODE must be 0 or 1");
    end

    buf_state_e         state_reg, state_next;
    logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               afull_reg;
    logic [DATA_WD-1:0] rd_data;
    logic               is_empty, fire_in, fire_out, bypass, push, pop;

    assign is_empty = (state_reg == EMPTY);
    // Registered state only: no combinational path from ready_out to ready_in.
    assign ready_in = (state_reg != FULL) && !flush;

    if (MODE == MODE_FWFT) begin : g_fwft
        assign valid_out = !is_empty || (valid_in && !flush);
        assign data_out  = is_empty ? data_in : rd_data;
    end else begin : g_reg
        assign valid_out = !is_empty;
        assign data_out  = rd_data;
    end

    assign fire_in  = valid_in && ready_in;
    assign fire_out = valid_out && ready_out;
    // Fall-through beat consumed in the cycle it arrives never touches storage.
    assign bypass   = (MODE == MODE_FWFT) && is_empty && fire_in && fire_out;
    assign push     = fire_in && !bypass;
    assign pop      = fire_out && !bypass && !is_empty;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            state_next  = EMPTY;
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
            case (state_reg)
                EMPTY: begin
                    if (push && !pop) begin
                        state_next = PART;
                    end
                end
                PART: begin
                    if (push && !pop && (count_reg == CNT_LAST)) begin
                        state_next = FULL;
                    end else if (pop && !push && (count_reg == CNT_ONE)) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = PART;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= EMPTY;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            afull_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            afull_reg  <= (count_next >= CNT_AFULL);
        end
    end

    assign count = count_reg;
    assign afull = afull_reg;

    hs_buf_ram #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hs_elastic_buf.sv
// Scoreboard bench for hs_elastic_buf: one registered-output and one
// fall-through instance checked against an occupancy/queue reference model.
module tb_hs_elastic_buf;

    logic       clk;
    logic       rstn;
    logic       fl   [2];
    logic       vi   [2];
    logic [7:0] di   [2];
    logic       rdy  [2];
    logic       vo   [2];
    logic [7:0] dout [2];
    logic       ro   [2];
    logic [2:0] cnt  [2];
    logic       af   [2];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int mcnt     [2];
    int pop_n    [2];
    int pop_first[2];
    int pop_last [2];
    int maxc     [2];
    int done_cnt = 0;
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    hs_elastic_buf #(.DATA_WD(8), .DEPTH(4), .MODE(0)) u_reg (
        .clk(clk), .rstn(rstn), .flush(fl[0]), .valid_in(vi[0]), .data_in(di[0]),
        .ready_in(rdy[0]), .valid_out(vo[0]), .data_out(dout[0]), .ready_out(ro[0]),
        .count(cnt[0]), .afull(af[0])
    );

    hs_elastic_buf #(.DATA_WD(8), .DEPTH(4), .MODE(1)) u_fwft (
        .clk(clk), .rstn(rstn), .flush(fl[1]), .valid_in(vi[1]), .data_in(di[1]),
        .ready_in(rdy[1]), .valid_out(vo[1]), .data_out(dout[1]), .ready_out(ro[1]),
        .count(cnt[1]), .afull(af[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int d, input logic [7:0] v);
        if (d == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    task automatic sb_pop(input int d, output logic [7:0] v, output logic ok);
        ok = 1'b0;
        v  = '0;
        if (d == 0 && sb0.size() > 0) begin v = sb0.pop_front(); ok = 1'b1; end
        if (d == 1 && sb1.size() > 0) begin v = sb1.pop_front(); ok = 1'b1; end
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) sb0.delete();
        else        sb1.delete();
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    // Reference model: occupancy is accepted minus delivered beats, capped at 4.
    task automatic mon_step(input int d);
        logic       er, ev, fin, fout, ok;
        logic [7:0] exp;
        if (!rstn) begin
            mcnt[d] = 0;
            sb_clear(d);
        end
        er = (mcnt[d] < 4) && !fl[d];
        ev = (mcnt[d] > 0) || ((d == 1) && vi[d] && !fl[d]);
        chk($sformatf("ready_in[%0d]", d), 32'(rdy[d]), 32'(er));
        chk($sformatf("valid_out[%0d]", d), 32'(vo[d]), 32'(ev));
        chk($sformatf("count[%0d]", d), 32'(cnt[d]), mcnt[d]);
        chk($sformatf("afull[%0d]", d), 32'(af[d]), 32'(mcnt[d] >= 3));
        if (int'(cnt[d]) > maxc[d]) maxc[d] = int'(cnt[d]);
        if (!rstn) return;
        fin  = vi[d] && er;
        fout = ev && ro[d];
        if (fout) begin
            sb_pop(d, exp, ok);
            chk($sformatf("beat_expected[%0d]", d), 32'(ok), 32'(1));
            if (ok) chk($sformatf("data_out[%0d]", d), 32'(dout[d]), 32'(exp));
            if (pop_n[d] == 0) pop_first[d] = cyc;
            pop_last[d] = cyc;
            pop_n[d]++;
        end
        if (fl[d]) begin
            mcnt[d] = 0;
            sb_clear(d);
        end else if (!(fin && fout && mcnt[d] == 0)) begin
            mcnt[d] = mcnt[d] + int'(fin) - int'(fout);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mon_step(0);
        mon_step(1);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [7:0] v);
        int t;
        vi[d] = 1'b1;
        di[d] = v;
        sb_push(d, v);
        t = 0;
        forever begin
            @(negedge clk);
            if (rdy[d]) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fails++;
                $display("FAIL send_timeout[%0d]: beat %0h not accepted, want accepted", d, v);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        vi[d] = 1'b0;
    endtask

    task automatic rand_prod(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(d, 8'($urandom));
        end
        done_cnt++;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fl[d] = 0; vi[d] = 0; di[d] = '0; ro[d] = 0;
            mcnt[d] = 0; pop_n[d] = 0; pop_first[d] = 0; pop_last[d] = 0; maxc[d] = 0;
        end
        repeat (3) step();
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready_in", 32'(rdy[0]), 1);
            chk("idle_count", 32'(cnt[0]), 0);
            step();
        end

        // Fill to FULL with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            send(0, 8'(8'hA0 + i));
            @(negedge clk);
            chk("fill_count", 32'(cnt[0]), i + 1);
            chk("fill_afull", 32'(af[0]), 32'(i + 1 >= 3));
            step();
        end
        vi[0] = 1'b1; di[0] = 8'hA4;
        repeat (2) begin
            @(negedge clk);
            chk("full_refuses", 32'(rdy[0]), 0);
            step();
        end
        vi[0] = 1'b0;
        @(negedge clk);
        chk("full_count", 32'(cnt[0]), 4);
        step();
        ro[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_data", 32'(dout[0]), 32'(8'hA0 + k));
            step();
        end
        @(negedge clk);
        chk("drain_count", 32'(cnt[0]), 0);
        step();

        // Back-to-back streaming.
        pop_n[0] = 0; maxc[0] = 0;
        for (int i = 0; i < 10; i++) send(0, 8'(i));
        repeat (3) step();
        chk("stream_beats", pop_n[0], 10);
        chk("stream_no_bubble", pop_last[0] - pop_first[0], 9);
        chk("stream_max_count", maxc[0], 1);

        // Backpressure hold.
        ro[0] = 1'b0;
        send(0, 8'h77);
        send(0, 8'h78);
        repeat (3) begin
            @(negedge clk);
            chk("hold_data", 32'(dout[0]), 32'h77);
            chk("hold_valid", 32'(vo[0]), 1);
            step();
        end
        ro[0] = 1'b1;
        repeat (4) step();

        // Pointer wrap with a toggling consumer.
        fork
            begin
                for (int i = 0; i < 9; i++) send(0, 8'(8'hC0 + i));
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    ro[0] = (k % 2 == 0);
                    step();
                end
                ro[0] = 1'b1;
            end
        join
        repeat (4) step();
        chk("wrap_drained", sb_size(0), 0);

        // Fall-through when empty.
        ro[1] = 1'b1; vi[1] = 1'b1; di[1] = 8'h55; sb_push(1, 8'h55);
        @(negedge clk);
        chk("fwft_pass_data", 32'(dout[1]), 32'h55);
        chk("fwft_pass_valid", 32'(vo[1]), 1);
        step();
        vi[1] = 1'b0;
        @(negedge clk);
        chk("fwft_pass_count", 32'(cnt[1]), 0);
        step();
        ro[1] = 1'b0; vi[1] = 1'b1; di[1] = 8'h55; sb_push(1, 8'h55);
        @(negedge clk);
        chk("fwft_stall_data", 32'(dout[1]), 32'h55);
        step();
        vi[1] = 1'b0;
        @(negedge clk);
        chk("fwft_store_count", 32'(cnt[1]), 1);
        chk("fwft_store_data", 32'(dout[1]), 32'h55);
        step();
        ro[1] = 1'b1;
        repeat (3) step();

        // Flush with a concurrent input beat.
        ro[0] = 1'b0;
        send(0, 8'h31); send(0, 8'h32); send(0, 8'h33);
        @(negedge clk);
        chk("preflush_count", 32'(cnt[0]), 3);
        step();
        fl[0] = 1'b1; vi[0] = 1'b1; di[0] = 8'hEE;
        @(negedge clk);
        chk("flush_ready_in", 32'(rdy[0]), 0);
        step();
        fl[0] = 1'b0; vi[0] = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(cnt[0]), 0);
        chk("flush_valid", 32'(vo[0]), 0);
        chk("flush_ready_after", 32'(rdy[0]), 1);
        step();
        ro[0] = 1'b1;
        repeat (3) step();

        // Randomised traffic on both instances.
        done_cnt = 0;
        fork
            rand_prod(0, 60);
            rand_prod(1, 60);
            begin
                for (int k = 0; k < 5000 && done_cnt < 2; k++) begin
                    ro[0] = 1'($urandom_range(0, 1));
                    ro[1] = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        ro[0] = 1'b1; ro[1] = 1'b1;
        repeat (8) step();
        chk("rand_drained0", sb_size(0), 0);
        chk("rand_drained1", sb_size(1), 0);

        // Asynchronous reset mid-transfer.
        ro[0] = 1'b0;
        send(0, 8'h91); send(0, 8'h92);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_count", 32'(cnt[0]), 0);
        chk("async_rst_valid", 32'(vo[0]), 0);
        chk("async_rst_ready", 32'(rdy[0]), 1);
        chk("async_rst_afull", 32'(af[0]), 0);
        step();
        rstn = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
